// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multicycle MIPS main control FSM
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMACC = 4'd4,
        S_LWWB   = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BCMP   = 4'd10,
        S_BTGT   = 4'd11,
        S_BTAKE  = 4'd12,
        S_JUMP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_JUMP = 2'b01;

endpackage

// File: rtl/mc_funct_dec.sv
// rtl/mc_funct_dec.sv - R-type funct field to ALU control code and legality flag
module mc_funct_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic       o_illegal
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        o_illegal  = 1'b0;
        case (i_funct)
            FN_ADD:  o_alu_ctrl = ALU_ADD;
            FN_SUB:  o_alu_ctrl = ALU_SUB;
            FN_AND:  o_alu_ctrl = ALU_AND;
            FN_OR:   o_alu_ctrl = ALU_OR;
            FN_SLT:  o_alu_ctrl = ALU_SLT;
            default: o_illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS main control FSM (Moore, ALU executor initiator)
// Optional andi/ori immediate-logic support under MC_IMM_LOGIC_EN.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = mc_ctrl_pkg::STATE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         iOpcode,
    input  logic [5:0]         iFunct,
    input  logic               iZero,
    output logic [2:0]         oALUctrl,
    output logic               oALUSrcA,
    output logic [1:0]         oALUSrcB,
    output logic               oPCWrite,
    output logic [1:0]         oPCSource,
    output logic               oIorD,
    output logic               oMemRead,
    output logic               oMemWrite,
    output logic               oIRWrite,
    output logic               oRegWrite,
    output logic               oRegDst,
    output logic               oMemtoReg,
    output logic               oIllegal,
`ifdef MC_IMM_LOGIC_EN
    output logic               oZeroExt,
`endif
    output logic [STATE_W-1:0] oState
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_illegal_evt;
    logic [2:0] w_funct_ctrl;
    logic       w_funct_bad;

    mc_funct_dec u_funct_dec (
        .i_funct    (iFunct),
        .o_alu_ctrl (w_funct_ctrl),
        .o_illegal  (w_funct_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal_evt;
        end
    end

    always_comb begin
        w_next        = S_IDLE;
        w_illegal_evt = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (iOpcode)
                    OP_RTYPE: begin
                        if (w_funct_bad) begin
                            w_next        = S_FETCH;
                            w_illegal_evt = 1'b1;
                        end else begin
                            w_next = S_REXEC;
                        end
                    end
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_ADDI:      w_next = S_IEXEC;
`ifdef MC_IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: w_next = S_IEXEC;
`endif
                    OP_BEQ:       w_next = S_BCMP;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next        = S_FETCH;
                        w_illegal_evt = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next = S_MEMACC;
            S_MEMACC: w_next = (iOpcode == OP_LW) ? S_LWWB : S_FETCH;
            S_LWWB:   w_next = S_FETCH;
            S_REXEC:  w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_IEXEC:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_BCMP:   w_next = S_BTGT;
            // iZero is registered by the ALU, so here it reflects the BCMP subtract.
            S_BTGT:   w_next = iZero ? S_BTAKE : S_FETCH;
            S_BTAKE:  w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            default: begin
                w_next        = S_IDLE;
                w_illegal_evt = 1'b1;
            end
        endcase
    end

    always_comb begin
        oALUctrl  = ALU_ADD;
        oALUSrcA  = 1'b0;
        oALUSrcB  = SRCB_B;
        oPCWrite  = 1'b0;
        oPCSource = PCSRC_ALU;
        oIorD     = 1'b0;
        oMemRead  = 1'b0;
        oMemWrite = 1'b0;
        oIRWrite  = 1'b0;
        oRegWrite = 1'b0;
        oRegDst   = 1'b0;
        oMemtoReg = 1'b0;
`ifdef MC_IMM_LOGIC_EN
        oZeroExt  = 1'b0;
`endif
        case (r_state)
            S_IDLE:   oALUctrl = 3'b000;
            S_FETCH: begin
                oMemRead = 1'b1;
                oIRWrite = 1'b1;
                oALUSrcB = SRCB_FOUR;
            end
            S_DECODE: oPCWrite = 1'b1;
            S_MEMADR: begin
                oALUSrcA = 1'b1;
                oALUSrcB = SRCB_IMM;
            end
            S_MEMACC: begin
                oIorD     = 1'b1;
                oMemRead  = (iOpcode == OP_LW);
                oMemWrite = (iOpcode == OP_SW);
            end
            S_LWWB: begin
                oRegWrite = 1'b1;
                oMemtoReg = 1'b1;
            end
            S_REXEC: begin
                oALUSrcA = 1'b1;
                oALUctrl = w_funct_ctrl;
            end
            S_RWB: begin
                oRegWrite = 1'b1;
                oRegDst   = 1'b1;
            end
            S_IEXEC: begin
                oALUSrcA = 1'b1;
                oALUSrcB = SRCB_IMM;
`ifdef MC_IMM_LOGIC_EN
                if (iOpcode == OP_ANDI) begin
                    oALUctrl = ALU_AND;
                    oZeroExt = 1'b1;
                end else if (iOpcode == OP_ORI) begin
                    oALUctrl = ALU_OR;
                    oZeroExt = 1'b1;
                end
`endif
            end
            S_IWB:    oRegWrite = 1'b1;
            S_BCMP: begin
                oALUSrcA = 1'b1;
                oALUctrl = ALU_SUB;
            end
            S_BTGT:   oALUSrcB = SRCB_IMM_SH;
            S_BTAKE:  oPCWrite = 1'b1;
            S_JUMP: begin
                oPCWrite  = 1'b1;
                oPCSource = PCSRC_JUMP;
            end
            default:  oALUctrl = 3'b000;
        endcase
    end

    assign oIllegal = r_illegal;
    assign oState   = r_state;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS main control FSM; the initiator side of the ALU executor interface.
- Decodes opcode/funct from the instruction register.
- Sequences fetch, decode, execute, memory and writeback; drives ALU control code, operand selects and datapath enables.
- Compensates for the ALU's one-cycle registered result and registered zero flag (zero = 1 iff A == B, sampled the same edge as res).

Parameters:
- STATE_W, 4, state register width (fixed; 14 states used).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iOpcode  in  6  IR[31:26]; stable from DECODE until next FETCH.
- iFunct  in  6  IR[5:0].
- iZero  in  1  registered ALU equality flag.
- oALUctrl  out  3  ALU op code: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- oALUSrcA  out  1  ALU A operand select: 0 PC, 1 A register.
- oALUSrcB  out  2  ALU B operand select: 00 B register, 01 const 4, 10 sext(imm), 11 sext(imm)<<2.
- oPCWrite  out  1  PC load enable.
- oPCSource  out  2  PC source: 00 ALU res, 01 jump target {PC[31:28], IR[25:0], 2'b00}.
- oIorD  out  1  memory address: 0 PC, 1 ALU res.
- oMemRead, oMemWrite, oIRWrite, oRegWrite  out  1 each  memory, IR and register-file enables.
- oRegDst  out  1  destination register: 1 rd, 0 rt.
- oMemtoReg  out  1  writeback data: 1 MDR, 0 ALU res.
- oIllegal  out  1  one-cycle pulse on an undecodable instruction.
- oState  out  4  current state, for debug.

Behaviour:
- Moore machine; outputs decode from the state register only (oIllegal is a registered pulse).
- Every output is deasserted / 0 unless listed for a state. oALUctrl defaults to 010.
- rst_n low: asynchronously enter IDLE. All outputs are 0 during and after reset, including oALUctrl = 000 and oIllegal = 0. Applies mid-instruction too; no partial write completes.
- IDLE(0): all outputs 0 -> FETCH.
- FETCH(1): MemRead, IRWrite, IorD=0, SrcA=0, SrcB=01, add -> DECODE.
- DECODE(2): PCWrite, PCSource=00 (res = PC+4); branch on iOpcode:
  - 0x00 -> REXEC; 0x23/0x2B -> MEMADR; 0x08 -> IEXEC; 0x04 -> BCMP; 0x02 -> JUMP.
  - Other opcodes -> FETCH with oIllegal pulsed the following cycle.
- MEMADR(3): SrcA=1, SrcB=10, add -> MEMACC.
- MEMACC(4): IorD=1; lw: MemRead -> LWWB; sw: MemWrite -> FETCH.
- LWWB(5): RegWrite, MemtoReg=1, RegDst=0 -> FETCH.
- REXEC(6): SrcA=1, SrcB=00, ctrl from funct -> RWB.
  - Funct map: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Any other funct: DECODE goes to FETCH instead, with oIllegal pulsed.
- RWB(7): RegWrite, RegDst=1, MemtoReg=0 -> FETCH.
- IEXEC(8): SrcA=1, SrcB=10, add -> IWB.
- IWB(9): RegWrite, RegDst=0 -> FETCH.
- BCMP(10): SrcA=1, SrcB=00, sub -> BTGT.
- BTGT(11): SrcA=0, SrcB=11, add (new PC + offset). iZero here reflects BCMP: 1 -> BTAKE, 0 -> FETCH.
- BTAKE(12): PCWrite, PCSource=00 -> FETCH.
- JUMP(13): PCWrite, PCSource=01 -> FETCH.
- Illegal encodings 14/15 -> IDLE next cycle, pulse oIllegal.
- Cycle counts from FETCH: R 4, lw 5, sw 4, addi 4, beq taken 5 / not taken 4, j 3.

Optional Feature:
- Macro MC_IMM_LOGIC_EN.
- Defined:
  - Opcodes 0x0C andi and 0x0D ori go DECODE -> IEXEC with ctrl 000 / 001 and SrcB=10.
  - Extra output oZeroExt (1 in IEXEC for andi/ori) makes the immediate zero-extended; IWB unchanged.
- Undefined: 0x0C / 0x0D are illegal; oZeroExt port absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - opcode and funct constants;
  - ALU ctrl codes;
  - SrcB and PCSource select codes.
- One sub-module, mc_funct_dec: funct -> {ALU ctrl[2:0], illegal}, combinational; used by both REXEC/RWB and the DECODE legality check.

Test Plan:
- Release rst_n; opcode 0x00, funct 0x22 -> states 1,2,6,7,1; oALUctrl=110 in REXEC; RegWrite=1, RegDst=1 only in RWB.
- lw (0x23) -> MEMADR SrcB=10 add; MEMACC IorD=1 MemRead=1; LWWB MemtoReg=1 RegWrite=1; 5 cycles total.
- beq with iZero=1 in BTGT -> BTAKE PCWrite=1 PCSource=00; with iZero=0 -> FETCH directly, PCWrite never asserted after DECODE.
- j (0x02) -> JUMP PCWrite=1 PCSource=01; back in FETCH after 3 cycles.
- Opcode 0x3F, then opcode 0x00 with funct 0x27 -> each returns to FETCH from DECODE, oIllegal high exactly one cycle, no RegWrite/MemWrite.
- rst_n low during MEMACC of sw -> same-cycle MemWrite=0, oState=0, all outputs 0; FETCH one cycle after release.
